// File: rtl/mem_stall_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store interface.
// One word access per request; Stall covers the busy window and Done pulses on completion.
module mem_stall_responder #(
  parameter int LATENCY = 4,
  parameter int MEM_AW  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] idx_q, idx_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              isWr_q, isWr_d;
  logic              err_q, err_d;
  logic              memWe;
  logic              req, legal, illegal;
  logic              addrUnused;

  logic [15:0] mem [2**MEM_AW];

  assign req        = Rd ^ Wr;
  assign legal      = req & ~Addr[0];
  assign illegal    = (Rd & Wr) | (req & Addr[0]);
  assign addrUnused = ^Addr[15:MEM_AW+1];

  // Stall rises in the accepting cycle itself so the pipeline latch freezes at once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    isWr_d  = isWr_q;
    err_d   = 1'b0;
    rdata_d = 16'h0000;
    memWe   = 1'b0;
    Stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal) begin
          state_d = BUSY;
          cnt_d   = 4'(LATENCY - 2);
          idx_d   = Addr[MEM_AW:1];
          wdata_d = DataIn;
          isWr_d  = Wr;
          Stall   = 1'b1;
        end else begin
          err_d = illegal;
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          memWe   = isWr_q;
          rdata_d = isWr_q ? 16'h0000 : mem[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!rst) Stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      isWr_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      isWr_q  <= isWr_d;
      err_q   <= err_d;
    end
  end

  // Storage is never reset; a reset during BUSY simply suppresses the commit.
  always_ff @(posedge clk) begin
    if (rst && memWe) mem[idx_q] <= wdata_q;
  end

  assign Done    = (state_q == DONE);
  assign DataOut = rdata_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_stall_responder.sv
// Self-checking bench: cycle-timeline reference model plus directed literal checks.
module tb_mem_stall_responder;

  localparam int LATENCY = 4;
  localparam int MEM_AW  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] Addr = 16'h0, DataIn = 16'h0;
  logic        Rd = 1'b0, Wr = 1'b0;
  logic [15:0] DataOut;
  logic        Done, Stall, err;

  logic [15:0] addr2 = 16'h0, data2 = 16'h0, dout2;
  logic        rd2 = 1'b0, wr2 = 1'b0, done2, stall2, err2;

  int checks = 0;
  int failures = 0;
  bit checkEn = 0;

  logic [MEM_AW-1:0] pool [6] = '{10'h010, 10'h022, 10'h004, 10'h3FF, 10'h000, 10'h155};
  logic [15:0]       poolInit [6] = '{16'hBEEF, 16'h0BAD, 16'h5555, 16'hC0DE, 16'h1111, 16'h2222};

  mem_stall_responder #(.LATENCY(LATENCY), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .err(err)
  );

  mem_stall_responder #(.LATENCY(2), .MEM_AW(MEM_AW)) dut2 (
    .clk(clk), .rst(rst), .Addr(addr2), .DataIn(data2), .Rd(rd2), .Wr(wr2),
    .DataOut(dout2), .Done(done2), .Stall(stall2), .err(err2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] data);
    @(posedge clk);
    #1;
    Rd = rd; Wr = wr; Addr = addr; DataIn = data;
  endtask

  task automatic doOp(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] data,
                      output logic [15:0] rdata);
    bit gotDone;
    gotDone = 0;
    rdata = 16'h0;
    applyStimulus(rd, wr, addr, data);
    for (int n = 0; n < 20 && !gotDone; n++) begin
      @(negedge clk);
      if (Done === 1'b1) begin
        gotDone = 1;
        rdata = DataOut;
      end
    end
    checkOutput("op_done_seen", {15'h0, gotDone}, 16'h1);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic lat2Op(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] data,
                        input logic [15:0] expData);
    @(posedge clk);
    #1;
    rd2 = rd; wr2 = wr; addr2 = addr; data2 = data;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("lat2_stall", {15'h0, stall2}, 16'h1);
      checkOutput("lat2_done_early", {15'h0, done2}, 16'h0);
    end
    @(negedge clk);
    checkOutput("lat2_done", {15'h0, done2}, 16'h1);
    checkOutput("lat2_stall_done", {15'h0, stall2}, 16'h0);
    checkOutput("lat2_data", dout2, expData);
    @(posedge clk);
    #1;
    rd2 = 1'b0; wr2 = 1'b0;
  endtask

  // Reference model: an accepted op owns cycles start..start+LATENCY; outputs follow from the offset.
  logic [15:0]       refMem [2**MEM_AW];
  bit                mActive = 0, mWr = 0, mErrNext = 0;
  int                mStart = 0, cyc = 0;
  logic [MEM_AW-1:0] mIdx = '0;
  logic [15:0]       mData = 16'h0;

  always @(negedge clk) begin : monitor
    logic        expStall, expDone, expErr, legal, illegal, wasIdle;
    logic [15:0] expData;
    int          k;
    cyc++;
    k = 0;
    expStall = 0; expDone = 0; expData = 16'h0; expErr = mErrNext;
    legal   = (Rd ^ Wr) && !Addr[0];
    illegal = (Rd && Wr) || ((Rd ^ Wr) && Addr[0]);
    wasIdle = !mActive;
    if (mActive) begin
      k = cyc - mStart;
      if (k < LATENCY) expStall = 1;
      else begin
        expDone = 1;
        expData = mWr ? 16'h0 : refMem[mIdx];
      end
    end else if (legal) begin
      expStall = 1;
    end
    if (!rst) expStall = 0;
    if (checkEn) begin
      checkOutput("model_stall", {15'h0, Stall}, {15'h0, expStall});
      checkOutput("model_done", {15'h0, Done}, {15'h0, expDone});
      checkOutput("model_data", DataOut, expData);
      checkOutput("model_err", {15'h0, err}, {15'h0, expErr});
    end
    mErrNext = rst && wasIdle && illegal;
    if (!rst) mActive = 0;
    else if (mActive) begin
      if (k == LATENCY - 1 && mWr) refMem[mIdx] = mData;
      if (k == LATENCY) mActive = 0;
    end else if (legal) begin
      mActive = 1; mStart = cyc; mWr = Wr; mIdx = Addr[MEM_AW:1]; mData = DataIn;
    end
  end

  initial begin
    logic [15:0] rdata;
    int          doneCnt, consec;
    bit          prevDone;
    int          r;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    checkEn = 1;
    @(negedge clk);
    checkOutput("reset_done", {15'h0, Done}, 16'h0);
    checkOutput("reset_stall", {15'h0, Stall}, 16'h0);
    checkOutput("reset_err", {15'h0, err}, 16'h0);
    checkOutput("reset_data", DataOut, 16'h0);

    for (int i = 0; i < 6; i++) begin
      doOp(1'b0, 1'b1, {5'h0, pool[i], 1'b0}, poolInit[i], rdata);
      checkOutput("preload_wr_data", rdata, 16'h0);
    end

    $display("[TB] read latency");
    applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0);
    for (int i = 0; i < LATENCY; i++) begin
      @(negedge clk);
      checkOutput("lat_stall", {15'h0, Stall}, 16'h1);
      checkOutput("lat_done_early", {15'h0, Done}, 16'h0);
    end
    @(negedge clk);
    checkOutput("lat_done", {15'h0, Done}, 16'h1);
    checkOutput("lat_stall_in_done", {15'h0, Stall}, 16'h0);
    checkOutput("lat_data", DataOut, 16'hBEEF);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);

    doOp(1'b1, 1'b0, 16'hF820, 16'h0, rdata);
    checkOutput("wrap_read", rdata, 16'hBEEF);

    $display("[TB] write then read");
    doOp(1'b0, 1'b1, 16'h0044, 16'h1234, rdata);
    checkOutput("wr_done_data", rdata, 16'h0);
    doOp(1'b1, 1'b0, 16'h0044, 16'h0, rdata);
    checkOutput("rd_after_wr", rdata, 16'h1234);

    $display("[TB] errors");
    applyStimulus(1'b1, 1'b0, 16'h0021, 16'h0);
    @(negedge clk);
    checkOutput("odd_stall", {15'h0, Stall}, 16'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("odd_err", {15'h0, err}, 16'h1);
    checkOutput("odd_done", {15'h0, Done}, 16'h0);
    @(negedge clk);
    checkOutput("odd_err_clear", {15'h0, err}, 16'h0);
    applyStimulus(1'b1, 1'b1, 16'h0044, 16'hFFFF);
    @(negedge clk);
    checkOutput("both_stall", {15'h0, Stall}, 16'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("both_err", {15'h0, err}, 16'h1);
    doOp(1'b1, 1'b0, 16'h0044, 16'h0, rdata);
    checkOutput("both_mem_kept", rdata, 16'h1234);

    $display("[TB] held request");
    applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0);
    doneCnt = 0; consec = 0; prevDone = 0;
    for (int i = 0; i < 3 * (LATENCY + 1); i++) begin
      @(negedge clk);
      if (Done === 1'b1) begin
        doneCnt++;
        if (prevDone) consec++;
      end
      prevDone = (Done === 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    checkOutput("held_done_count", 16'(doneCnt), 16'd3);
    checkOutput("held_consecutive", 16'(consec), 16'd0);

    $display("[TB] reset mid-op");
    applyStimulus(1'b0, 1'b1, 16'h0008, 16'hAAAA);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_stall_low", {15'h0, Stall}, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b1; Rd = 1'b0; Wr = 1'b0;
    @(negedge clk);
    checkOutput("midrst_stall", {15'h0, Stall}, 16'h0);
    checkOutput("midrst_done", {15'h0, Done}, 16'h0);
    doOp(1'b1, 1'b0, 16'h0008, 16'h0, rdata);
    checkOutput("midrst_old_value", rdata, 16'h5555);

    $display("[TB] latency 2 instance");
    lat2Op(1'b0, 1'b1, 16'h0006, 16'h7777, 16'h0);
    lat2Op(1'b1, 1'b0, 16'h0006, 16'h0, 16'h7777);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    {5'($urandom_range(0, 31)), pool[$urandom_range(0, 5)], 1'($urandom_range(0, 9) == 0)},
                    16'($urandom));
      rst = (r >= 2);
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b1;
    repeat (LATENCY + 3) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
